ecc_scalar_sequencer: RTL and testbench

Sequences one elliptic-curve scalar multiplication Q = k·P by issuing a stream of point-level commands (load, double, add, store) to the shared point-arithmetic unit. It sits between the Avalon register file's START/DONE words and the point unit, replacing hand-sequenced software loops. It runs left-to-right double-and-add over a `KEY_W`-bit scalar with one command outstanding at a time. A compile-time option selects a constant-time schedule.

---
 rtl/ecc_scalar_sequencer_if.sv | 36 +++
 rtl/ecc_scalar_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_ecc_scalar_sequencer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ecc_scalar_sequencer_if.sv
// ecc_scalar_sequencer_if
//   Command channel between the scalar-multiplication sequencer and the shared
//   point-arithmetic unit. One command is outstanding at a time.
//
//   op_valid : sequencer -> unit, command valid (held until op_ready)
//   op_code  : sequencer -> unit, 000 LOAD_INF, 001 LOAD_BASE, 010 DBL,
//              011 ADD, 100 STORE
//   op_dummy : sequencer -> unit, ADD result is to be discarded
//   op_ready : unit -> sequencer, command accepted this cycle
//   op_done  : unit -> sequencer, one-cycle pulse when the accepted command ends
//
//   master : sequencer side
//   slave  : point-unit side
interface ecc_scalar_sequencer_if;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] op_code;
  logic       op_dummy;
  logic       op_done;

  modport master (
    output op_valid,
    output op_code,
    output op_dummy,
    input  op_ready,
    input  op_done
  );

  modport slave (
    input  op_valid,
    input  op_code,
    input  op_dummy,
    output op_ready,
    output op_done
  );
endinterface

// File: rtl/ecc_scalar_sequencer.sv
// ecc_scalar_sequencer
//   Sequences one scalar multiplication Q = k*P as a stream of point-level
//   commands (LOAD_INF / LOAD_BASE / DBL / ADD / STORE) using left-to-right
//   double-and-add over a KEY_W-bit scalar, one command outstanding at a time.
//
//   Compile-time option: ECC_SEQ_CONST_TIME_EN
//     undefined : leading zeros are skipped, ADD is issued only for 1 bits,
//                 op_dummy is tied 0.
//     defined   : starts with LOAD_INF, issues DBL+ADD for every bit (ADD for a
//                 0 bit is flagged op_dummy), ends with STORE.
//
//   Ports
//     clk      : clock, rising edge
//     reset_n  : asynchronous active-low reset
//     start    : level input, a 0->1 edge starts a job when idle
//     abort    : synchronous cancel, honoured in any state
//     scalar   : scalar k, captured on the accepted start edge
//     busy     : job in progress
//     done     : sticky completion flag, cleared by the next accepted start
//     zero     : last job had k = 0 (result is the point at infinity)
//     bit_idx  : index of the scalar bit currently being processed
//     op       : command channel to the point unit (master side)
module ecc_scalar_sequencer #(
  parameter int KEY_W = 256,
  parameter int IDX_W = $clog2(KEY_W)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [KEY_W-1:0] scalar,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic [IDX_W-1:0] bit_idx,
  ecc_scalar_sequencer_if.master op
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_ISSUE,
    ST_WAIT,
    ST_FINISH
  } state_t;

  localparam logic [2:0] OP_LOAD_INF  = 3'b000;
  localparam logic [2:0] OP_LOAD_BASE = 3'b001;
  localparam logic [2:0] OP_DBL       = 3'b010;
  localparam logic [2:0] OP_ADD       = 3'b011;
  localparam logic [2:0] OP_STORE     = 3'b100;

  state_t           state_reg,   state_next;
  logic [KEY_W-1:0] shift_reg,   shift_next;
  logic [IDX_W-1:0] bit_idx_reg, bit_idx_next;
  logic [2:0]       op_code_reg, op_code_next;
  logic             done_reg,    done_next;
  logic             zero_reg,    zero_next;
  logic             start_d_reg;
`ifdef ECC_SEQ_CONST_TIME_EN
  logic             op_dummy_reg, op_dummy_next;
`endif

  logic start_edge;
  logic cur_bit;
  logic advance;

  assign start_edge = start & ~start_d_reg;
  // The scalar is shifted left as bit_idx counts down, so the bit under
  // bit_idx is always the MSB of the shift register.
  assign cur_bit    = shift_reg[KEY_W-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      bit_idx_reg  <= '0;
      op_code_reg  <= OP_LOAD_INF;
      done_reg     <= 1'b0;
      zero_reg     <= 1'b0;
      start_d_reg  <= 1'b0;
`ifdef ECC_SEQ_CONST_TIME_EN
      op_dummy_reg <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bit_idx_reg  <= bit_idx_next;
      op_code_reg  <= op_code_next;
      done_reg     <= done_next;
      zero_reg     <= zero_next;
      // Tracks start unconditionally, so an edge coinciding with abort is lost.
      start_d_reg  <= start;
`ifdef ECC_SEQ_CONST_TIME_EN
      op_dummy_reg <= op_dummy_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_idx_next = bit_idx_reg;
    op_code_next = op_code_reg;
    done_next    = done_reg;
    zero_next    = zero_reg;
`ifdef ECC_SEQ_CONST_TIME_EN
    op_dummy_next = op_dummy_reg;
`endif
    advance      = 1'b0;

    if (abort) begin
      // done and zero are left as they are; any in-flight op_done is ignored
      // because it can only be acted on in ST_WAIT.
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_edge) begin
            shift_next   = scalar;
            bit_idx_next = IDX_W'(KEY_W - 1);
            done_next    = 1'b0;
`ifdef ECC_SEQ_CONST_TIME_EN
            zero_next     = (scalar == '0);
            op_code_next  = OP_LOAD_INF;
            op_dummy_next = 1'b0;
            state_next    = ST_ISSUE;
`else
            zero_next    = 1'b0;
            state_next   = ST_SCAN;
`endif
          end
        end

`ifndef ECC_SEQ_CONST_TIME_EN
        // Leading-zero skip: one bit per cycle until the first 1.
        ST_SCAN: begin
          if (cur_bit) begin
            op_code_next = OP_LOAD_BASE;
            state_next   = ST_ISSUE;
          end else if (bit_idx_reg != '0) begin
            shift_next   = {shift_reg[KEY_W-2:0], 1'b0};
            bit_idx_next = bit_idx_reg - IDX_W'(1);
          end else begin
            zero_next  = 1'b1;
            state_next = ST_FINISH;
          end
        end
`endif

        ST_ISSUE: begin
          if (op.op_ready) begin
            state_next = ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (op.op_done) begin
            state_next = ST_ISSUE;
`ifdef ECC_SEQ_CONST_TIME_EN
            op_dummy_next = 1'b0;
`endif
            case (op_code_reg)
              OP_STORE: state_next = ST_FINISH;
`ifdef ECC_SEQ_CONST_TIME_EN
              // R = O: the top bit still needs its own DBL, so no step yet.
              OP_LOAD_INF: op_code_next = OP_DBL;
              OP_DBL: begin
                op_code_next  = OP_ADD;
                op_dummy_next = ~cur_bit;
              end
`else
              OP_DBL: begin
                if (cur_bit) begin
                  op_code_next = OP_ADD;
                end else begin
                  advance = 1'b1;
                end
              end
`endif
              // LOAD_BASE and ADD close out the current bit.
              default: advance = 1'b1;
            endcase
          end
        end

        ST_FINISH: begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end

        default: state_next = ST_IDLE;
      endcase
    end

    // Move on to the next lower bit, or store once bit 0 is finished.
    if (advance) begin
      if (bit_idx_reg == '0) begin
        op_code_next = OP_STORE;
      end else begin
        bit_idx_next = bit_idx_reg - IDX_W'(1);
        shift_next   = {shift_reg[KEY_W-2:0], 1'b0};
        op_code_next = OP_DBL;
      end
    end
  end

  assign busy        = (state_reg != ST_IDLE);
  assign done        = done_reg;
  assign zero        = zero_reg;
  assign bit_idx     = bit_idx_reg;
  assign op.op_valid = (state_reg == ST_ISSUE);
  assign op.op_code  = op_code_reg;
`ifdef ECC_SEQ_CONST_TIME_EN
  assign op.op_dummy = op_dummy_reg;
`else
  assign op.op_dummy = 1'b0;
`endif

endmodule

// File: tb/tb_ecc_scalar_sequencer.sv
// tb_ecc_scalar_sequencer
//   Scoreboard bench for ecc_scalar_sequencer with KEY_W = 8. Expected command
//   words (code*2 + dummy) are pushed when a job is started and popped at each
//   command handshake. A point-unit model pulses op_done 3 cycles after every
//   handshake and can stall op_ready on the first DBL of a job.
`timescale 1ns/1ps
module tb_ecc_scalar_sequencer;

  localparam int KEY_W = 8;
  localparam int IDX_W = 3;

  localparam int C_LI  = 0;
  localparam int C_LB  = 1;
  localparam int C_DBL = 2;
  localparam int C_ADD = 3;
  localparam int C_ST  = 4;

`ifdef ECC_SEQ_CONST_TIME_EN
  localparam int N_0B        = 18;
  localparam int N_80        = 18;
  localparam int FIRST_DELTA = 0;
`else
  localparam int N_0B        = 7;
  localparam int N_80        = 9;
  localparam int FIRST_DELTA = 5;
`endif

  logic             clk     = 1'b0;
  logic             reset_n = 1'b0;
  logic             start   = 1'b0;
  logic             abort   = 1'b0;
  logic [KEY_W-1:0] scalar  = '0;
  logic             busy;
  logic             done;
  logic             zero;
  logic [IDX_W-1:0] bit_idx;

  ecc_scalar_sequencer_if op_if ();

  ecc_scalar_sequencer #(
    .KEY_W (KEY_W),
    .IDX_W (IDX_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .abort   (abort),
    .scalar  (scalar),
    .busy    (busy),
    .done    (done),
    .zero    (zero),
    .bit_idx (bit_idx),
    .op      (op_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  int hs_cnt = 0;
  int hs_base = 0;
  int done_cnt = 0;
  int stall_left = 0;
  int run_len = 0;
  bit run_check_armed = 0;
  bit prev_valid = 0;
  int last_code = 0;
  bit seen_valid = 0;
  int first_valid_cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;

  task automatic check_value(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic void push_expected(input logic [7:0] k);
`ifdef ECC_SEQ_CONST_TIME_EN
    exp_q.push_back(C_LI * 2);
    for (int i = 7; i >= 0; i--) begin
      exp_q.push_back(C_DBL * 2);
      exp_q.push_back(C_ADD * 2 + (k[i] ? 0 : 1));
    end
    exp_q.push_back(C_ST * 2);
`else
    begin
      int m;
      m = -1;
      for (int i = 0; i < 8; i++) if (k[i]) m = i;
      if (m >= 0) begin
        exp_q.push_back(C_LB * 2);
        for (int i = m - 1; i >= 0; i--) begin
          exp_q.push_back(C_DBL * 2);
          if (k[i]) exp_q.push_back(C_ADD * 2);
        end
        exp_q.push_back(C_ST * 2);
      end
    end
`endif
  endfunction

  // Point-unit model and command monitor, all on the falling edge.
  initial begin
    op_if.op_ready = 1'b1;
    op_if.op_done  = 1'b0;
    forever begin
      @(negedge clk);
      op_if.op_done = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) op_if.op_done = 1'b1;
      end
      if (op_if.op_valid && int'(op_if.op_code) == C_DBL && stall_left > 0) begin
        op_if.op_ready = 1'b0;
        stall_left--;
        if (stall_left == 2) op_if.op_done = 1'b1;  // spurious, must be ignored
      end else begin
        op_if.op_ready = 1'b1;
      end
      if (op_if.op_valid) begin
        if (!seen_valid) begin
          seen_valid      = 1'b1;
          first_valid_cyc = cyc;
        end
        if (prev_valid && int'(op_if.op_code) == last_code) run_len++;
        else run_len = 1;
      end
      prev_valid = op_if.op_valid;
      last_code  = int'(op_if.op_code);
      if (op_if.op_valid && op_if.op_ready) begin
        int word;
        word = int'(op_if.op_code) * 2 + int'(op_if.op_dummy);
        if (exp_q.size() == 0) begin
          check_value("cmd_underflow", exp_q.size(), 1);
        end else begin
          int e;
          e = exp_q.pop_front();
          $display("cmd #%0d code=%0d dummy=%0d (expected code=%0d dummy=%0d)",
                   hs_cnt - hs_base, word / 2, word % 2, e / 2, e % 2);
          check_value($sformatf("cmd%0d", hs_cnt - hs_base), word, e);
        end
        if (run_check_armed && int'(op_if.op_code) == C_DBL) begin
          check_value("stall_valid_stable_cycles", run_len, 5);
          run_check_armed = 1'b0;
        end
        hs_cnt++;
        done_cnt = 3;
      end
    end
  end

  task automatic start_job(input logic [7:0] k, input bit keep_high);
    push_expected(k);
    seen_valid = 1'b0;
    hs_base    = hs_cnt;
    @(negedge clk);
    scalar = k;
    start  = 1'b1;
    @(negedge clk);
    start_cyc = cyc;
    check_value("busy_after_start", int'(busy), 1);
    check_value("bit_idx_after_start", int'(bit_idx), KEY_W - 1);
    check_value("done_cleared", int'(done), 0);
    if (!keep_high) start = 1'b0;
    scalar = ~k;
  endtask

  task automatic wait_done(input logic [7:0] k);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    done_cyc = cyc;
    check_value("done_within_budget", int'(n < 3000), 1);
    check_value("done_flag", int'(done), 1);
    check_value("busy_at_done", int'(busy), 0);
    check_value("zero_flag", int'(zero), int'(k == 8'h00));
    check_value("queue_drained", exp_q.size(), 0);
    $display("job k=%02h: %0d commands, done after %0d cycles, zero=%0d",
             k, hs_cnt - hs_base, done_cyc - start_cyc, zero);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int busy_seen;
    int h;

    repeat (3) @(negedge clk);
    check_value("rst_busy", int'(busy), 0);
    check_value("rst_done", int'(done), 0);
    check_value("rst_zero", int'(zero), 0);
    check_value("rst_op_valid", int'(op_if.op_valid), 0);
    check_value("rst_op_dummy", int'(op_if.op_dummy), 0);
    check_value("rst_op_code", int'(op_if.op_code), 0);
    check_value("rst_bit_idx", int'(bit_idx), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_value("post_rst_busy", int'(busy), 0);

    // Basic job
    start_job(8'h0B, 1'b0);
    wait_done(8'h0B);
    check_value("first_valid_delay", first_valid_cyc - start_cyc, FIRST_DELTA);
    check_value("cmds_0B", hs_cnt - hs_base, N_0B);

    // Zero scalar
    start_job(8'h00, 1'b0);
    wait_done(8'h00);
`ifndef ECC_SEQ_CONST_TIME_EN
    check_value("zero_no_valid", int'(seen_valid), 0);
    check_value("zero_done_delay", done_cyc - start_cyc, 9);
`endif

    // op_ready stall on the first DBL plus a spurious op_done
    stall_left      = 4;
    run_check_armed = 1'b1;
    start_job(8'h0B, 1'b0);
    wait_done(8'h0B);
    check_value("stall_consumed", stall_left, 0);
    check_value("stall_checked", int'(run_check_armed), 0);
    check_value("cmds_stall", hs_cnt - hs_base, N_0B);

    // Abort in WAIT after the second command
    start_job(8'h0B, 1'b0);
    n = 0;
    while (hs_cnt - hs_base < 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_value("abort_reached_cmd2", int'(n < 500), 1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_value("abort_busy", int'(busy), 0);
    check_value("abort_op_valid", int'(op_if.op_valid), 0);
    check_value("abort_done", int'(done), 0);
    check_value("abort_zero", int'(zero), 0);
    exp_q.delete();
    h = hs_cnt;
    repeat (6) @(negedge clk);
    check_value("abort_stays_idle", int'(busy), 0);
    check_value("abort_no_cmds", hs_cnt - h, 0);
    start_job(8'h80, 1'b0);
    wait_done(8'h80);
    check_value("cmds_80", hs_cnt - hs_base, N_80);

    // START held high through and after completion
    start_job(8'h0B, 1'b1);
    wait_done(8'h0B);
    check_value("cmds_hold", hs_cnt - hs_base, N_0B);
    h = hs_cnt;
    busy_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    check_value("hold_no_retrigger_cmds", hs_cnt - h, 0);
    check_value("hold_no_retrigger_busy", busy_seen, 0);
    start = 1'b0;

    // START pulse while busy
    start_job(8'h0B, 1'b0);
    repeat (8) @(negedge clk);
    check_value("busy_before_pulse", int'(busy), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(8'h0B);
    check_value("cmds_pulse", hs_cnt - hs_base, N_0B);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
